// File: rtl/proc_defs_pkg.sv
// Shared ISA constants for the instruction pipeline control slice:
// opcode/aluop encodings, instruction field positions, bubble word and
// the multdiv busy FSM state type.
package proc_defs_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSN = 32'd0;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_LED  = 5'b01010;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Opcodes that read their rd field as a source operand in decode.
  function automatic logic reads_rd(input logic [4:0] op);
    return (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEQ) ||
           (op == OP_JR)  || (op == OP_LED);
  endfunction

endpackage

// File: rtl/insn_pipe_ctrl_if.sv
// Bundle of the pipeline controller's fetch/branch/multdiv inputs and its
// pipeline-register, stall and status outputs. The controller is the slave.
interface insn_pipe_ctrl_if #(
  parameter int INSN_W      = 32,
  parameter int STALL_CNT_W = 16
);
  logic [INSN_W-1:0]      imem_insn;
  logic                   branch_taken;
  logic                   md_rdy;
  logic [INSN_W-1:0]      fd_insn;
  logic [INSN_W-1:0]      dx_insn;
  logic [INSN_W-1:0]      xm_insn;
  logic [INSN_W-1:0]      mw_insn;
  logic                   pc_en;
  logic                   md_start;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   md_timeout;

  modport master (
    output imem_insn, branch_taken, md_rdy,
    input  fd_insn, dx_insn, xm_insn, mw_insn,
    input  pc_en, md_start, stall_cycles, md_timeout
  );

  modport slave (
    input  imem_insn, branch_taken, md_rdy,
    output fd_insn, dx_insn, xm_insn, mw_insn,
    output pc_en, md_start, stall_cycles, md_timeout
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the F/D and D/X instruction words.
// A store behind a load of its data register is not flagged: the W->M
// bypass forwards it. Register 0 never creates a hazard.
module hazard_detect
  import proc_defs_pkg::*;
(
  input  logic [WORD_W-1:0] fd_insn,
  input  logic [WORD_W-1:0] dx_insn,
  output logic              load_use
);

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd;

  assign fd_op = fd_insn[OP_HI:OP_LO];
  assign fd_rd = fd_insn[RD_HI:RD_LO];
  assign fd_rs = fd_insn[RS_HI:RS_LO];
  assign fd_rt = fd_insn[RT_HI:RT_LO];
  assign dx_op = dx_insn[OP_HI:OP_LO];
  assign dx_rd = dx_insn[RD_HI:RD_LO];

  // Fields the hazard logic never looks at.
  logic unused_bits;
  assign unused_bits = ^{fd_insn[RT_LO-1:0], dx_insn[RD_LO-1:0]};

  // Flag a consumer in FD that reads the register the DX load writes.
  always_comb begin
    load_use = 1'b0;
    if (dx_op == OP_LW && dx_rd != 5'd0) begin
      load_use = (fd_rs == dx_rd) ||
                 (fd_op == OP_R && fd_rt == dx_rd) ||
                 (reads_rd(fd_op) && fd_rd == dx_rd);
    end
  end

endmodule

// File: rtl/insn_pipe_ctrl.sv
// FD/DX/XM/MW instruction-word registers with load-use stall, taken-branch
// flush and multdiv busy handling. Optional build macro
// MULTDIV_TIMEOUT_EN adds a forced multdiv release after MD_TIMEOUT busy
// cycles and a sticky md_timeout flag; without it md_timeout is tied 0.
module insn_pipe_ctrl
  import proc_defs_pkg::*;
#(
  parameter int                INSN_W      = WORD_W,
  parameter logic [INSN_W-1:0] NOP         = NOP_INSN,
  parameter int                STALL_CNT_W = 16
`ifdef MULTDIV_TIMEOUT_EN
  , parameter int              MD_TIMEOUT  = 64
`endif
) (
  input logic            clock,
  input logic            reset,
  insn_pipe_ctrl_if.slave bus
);

  logic [INSN_W-1:0]      fd_q, dx_q, xm_q, mw_q;
  md_state_t              state_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   load_use;
  logic                   dx_md;
  logic                   md_start_c;
  logic                   md_release;
  logic                   timeout_hit;
  logic                   pc_en_c;

  hazard_detect u_hazard (
    .fd_insn  (fd_q),
    .dx_insn  (dx_q),
    .load_use (load_use)
  );

  assign dx_md = (dx_q[OP_HI:OP_LO] == OP_R) &&
                 ((dx_q[ALU_HI:ALU_LO] == ALU_MUL) || (dx_q[ALU_HI:ALU_LO] == ALU_DIV));

  // A new launch only from IDLE, so an md_rdy coinciding with md_start is ignored.
  assign md_start_c = (state_q == MD_IDLE) && dx_md;
  assign md_release = (state_q == MD_BUSY) && (bus.md_rdy || timeout_hit);

  // PC/FD advance enable, in priority order busy > launch > branch > load-use.
  always_comb begin
    pc_en_c = 1'b1;
    if (state_q == MD_BUSY)  pc_en_c = md_release;
    else if (md_start_c)     pc_en_c = 1'b0;
    else if (bus.branch_taken) pc_en_c = 1'b1;
    else if (load_use)       pc_en_c = 1'b0;
  end

  // Pipeline registers, busy FSM and saturating stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fd_q    <= NOP;
      dx_q    <= NOP;
      xm_q    <= NOP;
      mw_q    <= NOP;
      state_q <= MD_IDLE;
      stall_q <= '0;
    end else begin
      if (!pc_en_c && stall_q != '1) stall_q <= stall_q + STALL_CNT_W'(1);

      if (state_q == MD_BUSY) begin
        if (md_release) begin
          fd_q    <= bus.imem_insn;
          dx_q    <= fd_q;
          xm_q    <= dx_q;
          mw_q    <= xm_q;
          state_q <= MD_IDLE;
        end else begin
          xm_q <= NOP;
          mw_q <= xm_q;
        end
      end else if (md_start_c) begin
        xm_q    <= NOP;
        mw_q    <= xm_q;
        state_q <= MD_BUSY;
      end else if (bus.branch_taken) begin
        fd_q <= NOP;
        dx_q <= NOP;
        xm_q <= dx_q;
        mw_q <= xm_q;
      end else if (load_use) begin
        dx_q <= NOP;
        xm_q <= dx_q;
        mw_q <= xm_q;
      end else begin
        fd_q <= bus.imem_insn;
        dx_q <= fd_q;
        xm_q <= dx_q;
        mw_q <= xm_q;
      end
    end
  end

`ifdef MULTDIV_TIMEOUT_EN
  localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);

  logic [MD_CNT_W-1:0] md_cnt_q;
  logic                md_timeout_q;

  assign timeout_hit = (state_q == MD_BUSY) && (md_cnt_q == '0);

  // Busy down-counter: loaded at launch, terminal count forces release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt_q     <= '0;
      md_timeout_q <= 1'b0;
    end else if (md_start_c) begin
      md_cnt_q <= MD_CNT_W'(MD_TIMEOUT - 1);
    end else if (state_q == MD_BUSY) begin
      if (md_release) md_cnt_q <= '0;
      else            md_cnt_q <= md_cnt_q - MD_CNT_W'(1);
      if (timeout_hit && !bus.md_rdy) md_timeout_q <= 1'b1;
    end
  end

  assign bus.md_timeout = md_timeout_q;
`else
  assign timeout_hit    = 1'b0;
  assign bus.md_timeout = 1'b0;
`endif

  assign bus.fd_insn      = fd_q;
  assign bus.dx_insn      = dx_q;
  assign bus.xm_insn      = xm_q;
  assign bus.mw_insn      = mw_q;
  assign bus.pc_en        = pc_en_c;
  assign bus.md_start     = md_start_c;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_insn_pipe_ctrl.sv
// Directed bench for insn_pipe_ctrl: reset, normal flow, load-use stalls,
// non-stalling cases, multdiv busy, taken branch, multdiv timeout (either
// build) and asynchronous reset during a multdiv.
module tb_insn_pipe_ctrl;
  import proc_defs_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_stall = '0;

  insn_pipe_ctrl_if bus ();

  insn_pipe_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {OP_R, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    bus.imem_insn = NOP_INSN;
    repeat (4) tick();
  endtask

  task automatic test_reset_init();
    reset = 1'b1;
    bus.imem_insn = NOP_INSN;
    bus.branch_taken = 1'b0;
    bus.md_rdy = 1'b0;
    tick();
    total++; if ({bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn} !== 128'd0)
      $display("FAIL rst_insn: got %h want 0", {bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn}); else passed++;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL rst_pc_en: got %b want 1", bus.pc_en); else passed++;
    total++; if (bus.md_start !== 1'b0) $display("FAIL rst_md_start: got %b want 0", bus.md_start); else passed++;
    total++; if (bus.stall_cycles !== 16'd0) $display("FAIL rst_stall: got %0d want 0", bus.stall_cycles); else passed++;
    total++; if (bus.md_timeout !== 1'b0) $display("FAIL rst_md_timeout: got %b want 0", bus.md_timeout); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal_flow();
    logic [31:0] ins [4];
    ins[0] = i_ins(OP_ADDI, 5'd1, 5'd0, 17'd10);
    ins[1] = i_ins(OP_ADDI, 5'd2, 5'd0, 17'd20);
    ins[2] = r_ins(5'd3, 5'd1, 5'd2, 5'd0);
    ins[3] = i_ins(OP_ADDI, 5'd4, 5'd0, 17'd30);
    for (int i = 0; i < 4; i++) begin
      bus.imem_insn = ins[i];
      #1;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL nf_pc_en%0d: got %b want 1", i, bus.pc_en); else passed++;
      tick();
    end
    total++; if (bus.fd_insn !== ins[3]) $display("FAIL nf_fd: got %h want %h", bus.fd_insn, ins[3]); else passed++;
    total++; if (bus.dx_insn !== ins[2]) $display("FAIL nf_dx: got %h want %h", bus.dx_insn, ins[2]); else passed++;
    total++; if (bus.xm_insn !== ins[1]) $display("FAIL nf_xm: got %h want %h", bus.xm_insn, ins[1]); else passed++;
    total++; if (bus.mw_insn !== ins[0]) $display("FAIL nf_mw: got %h want %h", bus.mw_insn, ins[0]); else passed++;
    flush();
  endtask

  task automatic test_load_use();
    logic [31:0] lw, nxt;
    logic [31:0] cons [3];
    lw      = i_ins(OP_LW, 5'd5, 5'd3, 17'd4);
    nxt     = i_ins(OP_ADDI, 5'd7, 5'd0, 17'd1);
    cons[0] = r_ins(5'd1, 5'd5, 5'd2, 5'd0);
    cons[1] = r_ins(5'd1, 5'd2, 5'd5, 5'd0);
    cons[2] = i_ins(OP_BNE, 5'd5, 5'd6, 17'd8);
    for (int i = 0; i < 3; i++) begin
      flush();
      bus.imem_insn = lw;
      tick();
      bus.imem_insn = cons[i];
      tick();
      bus.imem_insn = nxt;
      #1;
      total++; if (bus.pc_en !== 1'b0) $display("FAIL lu_pc_en%0d: got %b want 0", i, bus.pc_en); else passed++;
      tick();
      exp_stall = exp_stall + 16'd1;
      total++; if (bus.fd_insn !== cons[i] || bus.dx_insn !== NOP_INSN || bus.xm_insn !== lw)
        $display("FAIL lu_bubble%0d: got fd=%h dx=%h xm=%h want fd=%h dx=0 xm=%h", i, bus.fd_insn, bus.dx_insn, bus.xm_insn, cons[i], lw);
      else passed++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL lu_one_cycle%0d: got %b want 1", i, bus.pc_en); else passed++;
      total++; if (bus.stall_cycles !== exp_stall) $display("FAIL lu_stall%0d: got %0d want %0d", i, bus.stall_cycles, exp_stall); else passed++;
      tick();
      total++; if (bus.fd_insn !== nxt || bus.dx_insn !== cons[i] || bus.mw_insn !== lw)
        $display("FAIL lu_advance%0d: got fd=%h dx=%h mw=%h want fd=%h dx=%h mw=%h", i, bus.fd_insn, bus.dx_insn, bus.mw_insn, nxt, cons[i], lw);
      else passed++;
    end
    flush();
  endtask

  task automatic test_no_stall();
    logic [31:0] lds [2];
    logic [31:0] cons [2];
    lds[0]  = i_ins(OP_LW, 5'd5, 5'd3, 17'd4);
    cons[0] = i_ins(OP_SW, 5'd5, 5'd3, 17'd0);
    lds[1]  = i_ins(OP_LW, 5'd0, 5'd3, 17'd4);
    cons[1] = r_ins(5'd1, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      flush();
      bus.imem_insn = lds[i];
      tick();
      bus.imem_insn = cons[i];
      tick();
      bus.imem_insn = NOP_INSN;
      #1;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL ns_pc_en%0d: got %b want 1", i, bus.pc_en); else passed++;
      tick();
      total++; if (bus.dx_insn !== cons[i]) $display("FAIL ns_dx%0d: got %h want %h", i, bus.dx_insn, cons[i]); else passed++;
    end
    total++; if (bus.stall_cycles !== exp_stall) $display("FAIL ns_stall: got %0d want %0d", bus.stall_cycles, exp_stall); else passed++;
    flush();
  endtask

  task automatic test_multdiv();
    logic [31:0] pre, mul, aft, nxt2;
    pre  = i_ins(OP_ADDI, 5'd9, 5'd0, 17'd3);
    mul  = r_ins(5'd6, 5'd1, 5'd2, ALU_MUL);
    aft  = i_ins(OP_ADDI, 5'd8, 5'd0, 17'd2);
    nxt2 = i_ins(OP_ADDI, 5'd10, 5'd0, 17'd4);
    bus.md_rdy = 1'b1;
    #1;
    total++; if (bus.pc_en !== 1'b1 || bus.md_start !== 1'b0)
      $display("FAIL md_rdy_idle: got pc_en=%b md_start=%b want 1 0", bus.pc_en, bus.md_start); else passed++;
    tick();
    bus.md_rdy = 1'b0;
    bus.imem_insn = pre;
    tick();
    bus.imem_insn = mul;
    tick();
    bus.imem_insn = aft;
    tick();
    bus.imem_insn = nxt2;
    #1;
    total++; if (bus.md_start !== 1'b1 || bus.pc_en !== 1'b0)
      $display("FAIL md_launch: got md_start=%b pc_en=%b want 1 0", bus.md_start, bus.pc_en); else passed++;
    tick();
    total++; if (bus.md_start !== 1'b0) $display("FAIL md_start_pulse: got %b want 0", bus.md_start); else passed++;
    total++; if (bus.fd_insn !== aft || bus.dx_insn !== mul || bus.xm_insn !== NOP_INSN || bus.mw_insn !== pre)
      $display("FAIL md_hold: got fd=%h dx=%h xm=%h mw=%h want %h %h 0 %h", bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn, aft, mul, pre);
    else passed++;
    for (int i = 1; i <= 5; i++) begin
      bus.branch_taken = (i == 3);
      #1;
      total++; if (bus.pc_en !== 1'b0 || bus.md_start !== 1'b0)
        $display("FAIL md_busy%0d: got pc_en=%b md_start=%b want 0 0", i, bus.pc_en, bus.md_start); else passed++;
      tick();
    end
    bus.branch_taken = 1'b0;
    total++; if (bus.fd_insn !== aft || bus.dx_insn !== mul || bus.mw_insn !== NOP_INSN)
      $display("FAIL md_branch_ignored: got fd=%h dx=%h mw=%h want %h %h 0", bus.fd_insn, bus.dx_insn, bus.mw_insn, aft, mul); else passed++;
    bus.md_rdy = 1'b1;
    #1;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL md_release_pc_en: got %b want 1", bus.pc_en); else passed++;
    tick();
    bus.md_rdy = 1'b0;
    exp_stall = exp_stall + 16'd6;
    total++; if (bus.fd_insn !== nxt2 || bus.dx_insn !== aft || bus.xm_insn !== mul || bus.mw_insn !== NOP_INSN)
      $display("FAIL md_advance: got fd=%h dx=%h xm=%h mw=%h want %h %h %h 0", bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn, nxt2, aft, mul);
    else passed++;
    total++; if (bus.stall_cycles !== exp_stall) $display("FAIL md_stall: got %0d want %0d", bus.stall_cycles, exp_stall); else passed++;
    total++; if (bus.pc_en !== 1'b1 || bus.md_start !== 1'b0)
      $display("FAIL md_idle_after: got pc_en=%b md_start=%b want 1 0", bus.pc_en, bus.md_start); else passed++;
    flush();
  endtask

  task automatic test_branch();
    logic [31:0] br, addi, tgt, lw, add;
    br   = i_ins(OP_BNE, 5'd1, 5'd2, 17'd8);
    addi = i_ins(OP_ADDI, 5'd5, 5'd0, 17'd1);
    tgt  = r_ins(5'd11, 5'd12, 5'd13, 5'd0);
    lw   = i_ins(OP_LW, 5'd5, 5'd3, 17'd4);
    add  = r_ins(5'd1, 5'd5, 5'd2, 5'd0);
    bus.imem_insn = br;
    tick();
    bus.imem_insn = addi;
    tick();
    bus.imem_insn = tgt;
    bus.branch_taken = 1'b1;
    #1;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL br_pc_en: got %b want 1", bus.pc_en); else passed++;
    tick();
    bus.branch_taken = 1'b0;
    total++; if (bus.fd_insn !== NOP_INSN || bus.dx_insn !== NOP_INSN || bus.xm_insn !== br)
      $display("FAIL br_flush: got fd=%h dx=%h xm=%h want 0 0 %h", bus.fd_insn, bus.dx_insn, bus.xm_insn, br); else passed++;
    tick();
    total++; if (bus.fd_insn !== tgt) $display("FAIL br_target: got %h want %h", bus.fd_insn, tgt); else passed++;
    flush();
    bus.imem_insn = lw;
    tick();
    bus.imem_insn = add;
    tick();
    bus.imem_insn = tgt;
    bus.branch_taken = 1'b1;
    #1;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL br_lu_pc_en: got %b want 1", bus.pc_en); else passed++;
    tick();
    bus.branch_taken = 1'b0;
    total++; if (bus.fd_insn !== NOP_INSN || bus.dx_insn !== NOP_INSN || bus.xm_insn !== lw)
      $display("FAIL br_lu_flush: got fd=%h dx=%h xm=%h want 0 0 %h", bus.fd_insn, bus.dx_insn, bus.xm_insn, lw); else passed++;
    total++; if (bus.stall_cycles !== exp_stall) $display("FAIL br_stall: got %0d want %0d", bus.stall_cycles, exp_stall); else passed++;
    flush();
  endtask

  task automatic test_timeout();
    logic [31:0] mul, aft;
    int lows;
    mul  = r_ins(5'd6, 5'd1, 5'd2, ALU_DIV);
    aft  = i_ins(OP_ADDI, 5'd8, 5'd0, 17'd2);
    lows = 0;
    bus.imem_insn = mul;
    tick();
    bus.imem_insn = aft;
    tick();
    bus.imem_insn = NOP_INSN;
    #1;
    total++; if (bus.md_start !== 1'b1) $display("FAIL to_launch: got %b want 1", bus.md_start); else passed++;
    if (bus.pc_en !== 1'b1) lows++;
    tick();
`ifdef MULTDIV_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      if (k == 63) begin
        total++; if (bus.md_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", bus.md_timeout); else passed++;
      end
      if (k == 64) begin
        total++; if (bus.pc_en !== 1'b1) $display("FAIL to_release: got %b want 1", bus.pc_en); else passed++;
      end else if (bus.pc_en !== 1'b1) begin
        lows++;
      end
      tick();
    end
    exp_stall = exp_stall + 16'd64;
    total++; if (lows != 64) $display("FAIL to_lows: got %0d want 64", lows); else passed++;
    total++; if (bus.md_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", bus.md_timeout); else passed++;
    total++; if (bus.dx_insn !== aft) $display("FAIL to_advance: got %h want %h", bus.dx_insn, aft); else passed++;
    total++; if (bus.stall_cycles !== exp_stall) $display("FAIL to_stall: got %0d want %0d", bus.stall_cycles, exp_stall); else passed++;
    tick();
    tick();
    total++; if (bus.md_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", bus.md_timeout); else passed++;
`else
    for (int k = 1; k <= 150; k++) begin
      if (bus.pc_en !== 1'b1) lows++;
      tick();
    end
    exp_stall = exp_stall + 16'd151;
    total++; if (lows != 151) $display("FAIL to_lows: got %0d want 151", lows); else passed++;
    total++; if (bus.md_timeout !== 1'b0) $display("FAIL to_flag: got %b want 0", bus.md_timeout); else passed++;
    total++; if (bus.dx_insn !== mul) $display("FAIL to_hold: got %h want %h", bus.dx_insn, mul); else passed++;
    total++; if (bus.stall_cycles !== exp_stall) $display("FAIL to_stall: got %0d want %0d", bus.stall_cycles, exp_stall); else passed++;
`endif
  endtask

  task automatic test_reset_mid_multdiv();
`ifdef MULTDIV_TIMEOUT_EN
    logic [31:0] mul;
    mul = r_ins(5'd6, 5'd1, 5'd2, ALU_MUL);
    flush();
    bus.imem_insn = mul;
    tick();
    bus.imem_insn = NOP_INSN;
    tick();
    tick();
    tick();
`endif
    total++; if (bus.pc_en !== 1'b0) $display("FAIL rm_busy: got %b want 0", bus.pc_en); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn} !== 128'd0)
      $display("FAIL rm_insn: got %h want 0", {bus.fd_insn, bus.dx_insn, bus.xm_insn, bus.mw_insn}); else passed++;
    total++; if (bus.pc_en !== 1'b1) $display("FAIL rm_pc_en: got %b want 1", bus.pc_en); else passed++;
    total++; if (bus.stall_cycles !== 16'd0) $display("FAIL rm_stall: got %0d want 0", bus.stall_cycles); else passed++;
    total++; if (bus.md_timeout !== 1'b0) $display("FAIL rm_md_timeout: got %b want 0", bus.md_timeout); else passed++;
    tick();
    reset = 1'b0;
    bus.imem_insn = NOP_INSN;
    #1;
    total++; if (bus.md_start !== 1'b0) $display("FAIL rm_no_start: got %b want 0", bus.md_start); else passed++;
    tick();
    total++; if (bus.pc_en !== 1'b1) $display("FAIL rm_busy_cleared: got %b want 1", bus.pc_en); else passed++;
  endtask

  initial begin
    test_reset_init();
    test_normal_flow();
    test_load_use();
    test_no_stall();
    test_multdiv();
    test_branch();
    test_timeout();
    test_reset_mid_multdiv();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
